// File: rtl/mux_rr_reg.sv
// rtl/mux_rr_reg.sv - registered N-channel valid/ready mux with fixed-select and round-robin modes
module mux_rr_reg #(
   parameter int WIDTH = 8,
   parameter int NCH   = 4,
   parameter int SELW  = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 mode,
   input  logic [SELW-1:0]      sel,
   input  logic [NCH*WIDTH-1:0] in_data,
   input  logic [NCH-1:0]       in_valid,
   output logic [NCH-1:0]       in_ready,
   output logic [WIDTH-1:0]     out_data,
   output logic [SELW-1:0]      out_sel,
   output logic                 out_valid,
   input  logic                 out_ready
);

   logic [WIDTH-1:0]     data_q, data_d;
   logic [SELW-1:0]      sel_q, sel_d;
   logic                 valid_q, valid_d;
   logic [SELW-1:0]      rr_ptr_q, rr_ptr_d;

   logic                 load_en;
   logic                 grant_vld;
   logic [SELW-1:0]      grant_idx;
   logic [WIDTH-1:0]     grant_data;
   logic [2**SELW-1:0]   vld_pad;
   logic [2**SELW-1:0]   rdy_pad;

   assign load_en = !valid_q || out_ready;

   // Padded valid vector lets an out-of-range sel index safely and read as "not valid".
   always_comb begin
      int cand;
      cand      = 0;
      vld_pad   = '0;
      vld_pad[NCH-1:0] = in_valid;
      grant_vld = 1'b0;
      grant_idx = '0;
      if (!mode) begin
         if (int'(sel) < NCH && vld_pad[sel]) begin
            grant_vld = 1'b1;
            grant_idx = sel;
         end
      end else begin
         // Walk offsets from farthest to nearest so the nearest valid channel after rr_ptr wins.
         for (int k = NCH; k >= 1; k--) begin
            cand = (int'(rr_ptr_q) + k) % NCH;
            if (vld_pad[cand[SELW-1:0]]) begin
               grant_vld = 1'b1;
               grant_idx = cand[SELW-1:0];
            end
         end
      end
   end

   assign grant_data = in_data[grant_idx*WIDTH +: WIDTH];

   always_comb begin
      rdy_pad = '0;
      if (load_en && grant_vld) begin
         rdy_pad[grant_idx] = 1'b1;
      end
   end

   assign in_ready = rdy_pad[NCH-1:0];

   always_comb begin
      data_d   = data_q;
      sel_d    = sel_q;
      valid_d  = valid_q;
      rr_ptr_d = rr_ptr_q;
      if (load_en) begin
         valid_d = grant_vld;
         if (grant_vld) begin
            data_d   = grant_data;
            sel_d    = grant_idx;
            rr_ptr_d = grant_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         sel_q    <= '0;
         valid_q  <= 1'b0;
         rr_ptr_q <= SELW'(NCH - 1);
      end else begin
         data_q   <= data_d;
         sel_q    <= sel_d;
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_rr_reg.sv
// tb/tb_mux_rr_reg.sv - self-checking bench for mux_rr_reg with a 4-channel and a 3-channel instance
module tb_mux_rr_reg;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        mode_a, ordy_a, ovalid_a;
   logic [1:0]  sel_a, osel_a;
   logic [31:0] data_a;
   logic [3:0]  valid_a, ready_a;
   logic [7:0]  odata_a;

   logic        mode_b, ordy_b, ovalid_b;
   logic [1:0]  sel_b, osel_b;
   logic [23:0] data_b;
   logic [2:0]  valid_b, ready_b;
   logic [7:0]  odata_b;

   mux_rr_reg #(.WIDTH(8), .NCH(4), .SELW(2)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .mode(mode_a), .sel(sel_a),
      .in_data(data_a), .in_valid(valid_a), .in_ready(ready_a),
      .out_data(odata_a), .out_sel(osel_a), .out_valid(ovalid_a), .out_ready(ordy_a)
   );

   mux_rr_reg #(.WIDTH(8), .NCH(3), .SELW(2)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .mode(mode_b), .sel(sel_b),
      .in_data(data_b), .in_valid(valid_b), .in_ready(ready_b),
      .out_data(odata_b), .out_sel(osel_b), .out_valid(ovalid_b), .out_ready(ordy_b)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what the output register should hold and who was served last.
   bit         m_valid[2];
   logic [7:0] m_data[2];
   int         m_sel[2];
   int         m_last[2];
   localparam int NCH_OF[2] = '{4, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input int nch, input int last, input bit md, input int s,
                               input logic [3:0] v);
      if (!md) return (s < nch && v[s] === 1'b1) ? s : -1;
      for (int k = 1; k <= nch; k++) begin
         if (v[(last + k) % nch] === 1'b1) return (last + k) % nch;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         m_valid[d] = 1'b0;
         m_data[d]  = 8'h00;
         m_sel[d]   = 0;
         m_last[d]  = NCH_OF[d] - 1;
      end
   endtask

   task automatic model_edge(input int d, input bit le, input int g, input logic [31:0] dat);
      logic [31:0] w;
      if (!le) return;
      if (g < 0) begin
         m_valid[d] = 1'b0;
      end else begin
         w = dat >> (8 * g);
         m_valid[d] = 1'b1;
         m_data[d]  = w[7:0];
         m_sel[d]   = g;
         m_last[d]  = g;
      end
   endtask

   task automatic tick();
      int ga, gb;
      bit la, lb;
      logic [31:0] da, db;
      #1;
      ga = pick(4, m_last[0], mode_a, int'(sel_a), valid_a);
      gb = pick(3, m_last[1], mode_b, int'(sel_b), {1'b0, valid_b});
      la = !m_valid[0] || ordy_a;
      lb = !m_valid[1] || ordy_b;
      chk("a_in_ready",  32'(ready_a),  (la && ga >= 0) ? (32'd1 << ga) : 32'd0);
      chk("a_out_valid", 32'(ovalid_a), 32'(m_valid[0]));
      chk("a_out_data",  32'(odata_a),  32'(m_data[0]));
      chk("a_out_sel",   32'(osel_a),   32'(m_sel[0]));
      chk("b_in_ready",  32'(ready_b),  (lb && gb >= 0) ? (32'd1 << gb) : 32'd0);
      chk("b_out_valid", 32'(ovalid_b), 32'(m_valid[1]));
      chk("b_out_data",  32'(odata_b),  32'(m_data[1]));
      chk("b_out_sel",   32'(osel_b),   32'(m_sel[1]));
      da = data_a;
      db = {8'h00, data_b};
      @(posedge clk);
      model_edge(0, la, ga, da);
      model_edge(1, lb, gb, db);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      model_reset();
      chk("rst_a_valid", 32'(ovalid_a), 32'd0);
      chk("rst_a_data",  32'(odata_a),  32'd0);
      chk("rst_a_sel",   32'(osel_a),   32'd0);
      chk("rst_b_valid", 32'(ovalid_b), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      mode_a = 1'b0; sel_a = 2'd0; data_a = '0; valid_a = '0; ordy_a = 1'b1;
      mode_b = 1'b0; sel_b = 2'd0; data_b = '0; valid_b = '0; ordy_b = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      do_reset();

      // fixed select picks channel 2
      mode_a = 1'b0; sel_a = 2'd2; valid_a = 4'b1111; data_a = 32'h44A5_2211;
      #1;
      chk("t1_in_ready", 32'(ready_a), 32'b0100);
      tick();
      chk("t1_out_data",  32'(odata_a),  32'hA5);
      chk("t1_out_sel",   32'(osel_a),   32'd2);
      chk("t1_out_valid", 32'(ovalid_a), 32'd1);

      // round-robin from reset: 0,1,2,3,0,1 with no bubbles
      do_reset();
      mode_a = 1'b1; valid_a = 4'b1111; ordy_a = 1'b1;
      for (int i = 0; i < 6; i++) begin
         data_a = $urandom;
         tick();
         chk("t2_rr_sel",   32'(osel_a),   32'(i % 4));
         chk("t2_rr_valid", 32'(ovalid_a), 32'd1);
      end

      // sparse round-robin: only channels 1 and 3
      do_reset();
      mode_a = 1'b1; valid_a = 4'b1010;
      for (int i = 0; i < 4; i++) begin
         data_a = $urandom;
         tick();
         chk("t3_sparse_sel", 32'(osel_a), (i % 2 == 0) ? 32'd1 : 32'd3);
      end

      // backpressure holds 0x3C, then drain and load on the same edge
      mode_a = 1'b0; sel_a = 2'd0; valid_a = 4'b0001; data_a = 32'h0000_003C; ordy_a = 1'b1;
      tick();
      data_a = 32'h0000_0011; ordy_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t4_hold_data",  32'(odata_a), 32'h3C);
         chk("t4_hold_ready", 32'(ready_a), 32'd0);
      end
      ordy_a = 1'b1;
      #1;
      chk("t4_release_ready", 32'(ready_a), 32'b0001);
      tick();
      chk("t4_next_data",  32'(odata_a),  32'h11);
      chk("t4_next_valid", 32'(ovalid_a), 32'd1);

      // out-of-range select on the 3-channel instance
      mode_b = 1'b0; sel_b = 2'd1; valid_b = 3'b111; data_b = 24'h33_22_11; ordy_b = 1'b1;
      tick();
      chk("t5_loaded", 32'(ovalid_b), 32'd1);
      sel_b = 2'd3;
      #1;
      chk("t5_oor_ready", 32'(ready_b), 32'd0);
      tick();
      chk("t5_oor_valid", 32'(ovalid_b), 32'd0);
      chk("t5_oor_hold",  32'(odata_b),  32'h22);

      // randomized traffic on both instances
      for (int i = 0; i < 300; i++) begin
         mode_a  = 1'($urandom);  sel_a = 2'($urandom); valid_a = 4'($urandom);
         data_a  = $urandom;      ordy_a = ($urandom_range(0, 3) != 0);
         mode_b  = 1'($urandom);  sel_b = 2'($urandom); valid_b = 3'($urandom);
         data_b  = 24'($urandom); ordy_b = ($urandom_range(0, 3) != 0);
         tick();
      end

      // reset while a word is registered
      mode_a = 1'b1; valid_a = 4'b1111; ordy_a = 1'b1; data_a = 32'hDEAD_BEEF;
      tick();
      tick();
      chk("t6_pre_valid", 32'(ovalid_a), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_async_valid", 32'(ovalid_a), 32'd0);
      chk("t6_async_data",  32'(odata_a),  32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();
      chk("t6_first_sel",   32'(osel_a),   32'd0);
      chk("t6_first_valid", 32'(ovalid_a), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
